if_fetch_stage: RTL and testbench
=================================

# if_fetch_stage

Instruction-fetch stage of the MIPS pipeline: holds the program counter, drives the byte address into the instruction memory, and captures the returned word into the IF/ID pipeline register. It is the stage directly upstream of instruction memory and directly upstream of decode. It handles stalls, flushes and redirects from later stages, resolves `j` early in fetch, and halts cleanly when the PC leaves the populated instruction memory.

## Interface
Parameters:
- `RESET_PC`, 32'd0: PC value loaded on reset.
- `IM_BYTES`, 84: populated instruction-memory size in bytes. Valid fetch requires PC ≤ IM_BYTES−4.

Ports:
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `Stall` in 1: hold PC and IF/ID contents.
- `Flush` in 1: load a bubble into IF/ID.
- `Redirect` in 1: taken branch from a later stage.
- `Redirect_addr` in 32: redirect target byte address.
- `IM_addr` out 32: byte address to instruction memory; combinationally equal to `PC`.
- `IM_instr` in 32: big-endian word returned by instruction memory, combinational from `IM_addr`.
- `PC` out 32: current program counter.
- `IFID_instr` out 32: registered instruction.
- `IFID_pc4` out 32: registered PC+4 of that instruction.
- `IFID_valid` out 1: IF/ID holds a real instruction.
- `Halt` out 1: PC is out of range and fetch is stopped.

## Operation
- PC[1:0] is always 00. `Redirect_addr[1:0]` and jump-target low bits are forced to 00.
- `in_range` = (PC ≤ IM_BYTES−4).
- `is_j` = `IM_instr[31:26]` == 6'd2, qualified by `in_range`.
- `jtgt` = {(PC+4)[31:28], IM_instr[25:0], 2'b00}.
- Next-PC priority, highest first:
  - `rst`: PC ← RESET_PC.
  - `Redirect`: PC ← Redirect_addr.
  - `Stall`: PC holds.
  - `!in_range`: PC holds.
  - `is_j`: PC ← jtgt (only with EARLY_JUMP_EN).
  - Otherwise: PC ← PC+4, 32-bit wrap-around.
- IF/ID update priority, highest first:
  - `rst`, `Redirect` or `Flush`: load bubble (instr 0, pc4 0, valid 0).
  - `Stall`: hold.
  - `!in_range`: load bubble.
  - Otherwise: instr ← IM_instr, pc4 ← PC+4, valid ← 1.
- A fetched `j` still enters IF/ID with valid=1. Downstream treats it as a no-op when EARLY_JUMP_EN is defined.
- `Halt` = !in_range and !rst. It is combinational from PC. It clears only on `Redirect` to an in-range address or on `rst`.
- `Redirect` together with `Stall` in the same cycle: Redirect wins for PC and IF/ID gets a bubble.
- `Flush` together with `Stall`: IF/ID gets a bubble and PC holds.
- Fetch uses no state machine beyond PC and IF/ID. The two effective modes are RUN (in_range) and HALT (!in_range), and both are fully derived from PC.

## Timing
- Reset values: PC=RESET_PC, IM_addr=RESET_PC, IFID_instr=0, IFID_pc4=0, IFID_valid=0, Halt=0 (with RESET_PC in range).
- `rst` asserted mid-run takes effect at the next edge and overrides every other input.
- Fetch latency: the word at PC appears on IFID_* one edge after PC holds that value.
- Sequential throughput is one instruction per cycle.
- Redirect penalty: one bubble in IF/ID. The target instruction appears in IF/ID two edges after Redirect is sampled.
- Early jump costs zero bubbles: the edge that captures the `j` into IF/ID also loads jtgt into PC.
- `Stall` is level-sensitive. While asserted, every output is constant unless Redirect or Flush is also active.

## Configuration
- `IF_EARLY_JUMP_EN` defined: `j` is resolved in fetch as described above, and `is_j` drives next-PC.
- `IF_EARLY_JUMP_EN` undefined: `is_j` logic is not compiled and PC always advances by 4. Jumps then rely on a later stage asserting `Redirect` with the jump target.

## Test plan
- Sequential fetch: reset, run 3 cycles with IM returning 32'h5109_4015 at PC 0. Required: PC goes 0→4→8→12, IFID_instr=32'h5109_4015 with IFID_pc4=4 and valid=1 after the 2nd edge.
- Stall and flush: at PC=8, hold Stall high for 2 cycles, then pulse Flush for 1 cycle. Required: PC stays 8 and IF/ID is unchanged during the stall; after the flush pulse, valid=0 and instr=0; PC=12 on the following edge.
- Early jump (macro on): PC=76 with `IM_instr`={6'd2, 26'd16}. Required: next PC=64, the `j` word sits in IF/ID with pc4=80, no bubble.
- Halt: jump to 26'd125. Required: PC=500, Halt=1, IFID_valid=0 on the next edge, PC stays 500 for 5 cycles. Then Redirect to 24: Halt=0, PC=24, and one bubble precedes the word from 24.
- Redirect during stall: Stall=1 and Redirect=1 with Redirect_addr=32'd43. Required: PC=40 (low bits forced), IFID_valid=0.
- Macro off: the same stimulus as the early-jump case gives PC=80 after the `j`; a following Redirect to 64 lands PC at 64.

Source files
------------

// File: rtl/if_fetch_stage.sv
// MIPS instruction-fetch stage: PC register, instruction-memory address, IF/ID pipeline register.
// Define IF_EARLY_JUMP_EN to resolve `j` in fetch; otherwise PC always advances by 4.
module if_fetch_stage #(
   parameter logic [31:0] RESET_PC = 32'd0,
   parameter int unsigned IM_BYTES = 84
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        Stall,
   input  logic        Flush,
   input  logic        Redirect,
   input  logic [31:0] Redirect_addr,
   output logic [31:0] IM_addr,
   input  logic [31:0] IM_instr,
   output logic [31:0] PC,
   output logic [31:0] IFID_instr,
   output logic [31:0] IFID_pc4,
   output logic        IFID_valid,
   output logic        Halt
);

   localparam logic [31:0] LAST_PC = 32'(IM_BYTES) - 32'd4;
   localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

   logic [31:0] pc_q, pc_d;
   logic [31:0] instr_q, instr_d;
   logic [31:0] pc4_q, pc4_d;
   logic        valid_q, valid_d;

   logic        in_range;
   logic [31:0] pc_plus4;
   logic [31:0] redirect_pc;
   logic [31:0] seq_pc;

   assign in_range    = (pc_q <= LAST_PC);
   assign pc_plus4    = pc_q + 32'd4;
   assign redirect_pc = Redirect_addr & ~32'd3;

`ifdef IF_EARLY_JUMP_EN
   logic        is_j;
   logic [31:0] jtgt;

   // Out-of-range words are never decoded; the fetch is halted there anyway.
   assign is_j   = in_range && (IM_instr[31:26] == 6'd2);
   assign jtgt   = {pc_plus4[31:28], IM_instr[25:0], 2'b00};
   assign seq_pc = is_j ? jtgt : pc_plus4;
`else
   assign seq_pc = pc_plus4;
`endif

   always_comb begin
      pc_d = pc_q;
      if (Redirect) begin
         pc_d = redirect_pc;
      end else if (Stall || !in_range) begin
         pc_d = pc_q;
      end else begin
         pc_d = seq_pc;
      end
   end

   // Redirect and Flush dominate Stall for IF/ID; a halted PC feeds bubbles.
   always_comb begin
      instr_d = instr_q;
      pc4_d   = pc4_q;
      valid_d = valid_q;
      if (Redirect || Flush) begin
         instr_d = 32'd0;
         pc4_d   = 32'd0;
         valid_d = 1'b0;
      end else if (Stall) begin
         instr_d = instr_q;
         pc4_d   = pc4_q;
         valid_d = valid_q;
      end else if (!in_range) begin
         instr_d = 32'd0;
         pc4_d   = 32'd0;
         valid_d = 1'b0;
      end else begin
         instr_d = IM_instr;
         pc4_d   = pc_plus4;
         valid_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q    <= RESET_PC_ALIGNED;
         instr_q <= 32'd0;
         pc4_q   <= 32'd0;
         valid_q <= 1'b0;
      end else begin
         pc_q    <= pc_d;
         instr_q <= instr_d;
         pc4_q   <= pc4_d;
         valid_q <= valid_d;
      end
   end

   assign PC         = pc_q;
   assign IM_addr    = pc_q;
   assign IFID_instr = instr_q;
   assign IFID_pc4   = pc4_q;
   assign IFID_valid = valid_q;
   assign Halt       = !in_range && !rst;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: directed scenarios then random traffic against a rule-level model.
// Works with or without IF_EARLY_JUMP_EN defined.
module tb_if_fetch_stage;

   localparam logic [31:0] LAST = 32'd80;

   logic        clk = 1'b0;
   logic        rst;
   logic        Stall;
   logic        Flush;
   logic        Redirect;
   logic [31:0] Redirect_addr;
   logic [31:0] IM_addr;
   logic [31:0] IM_instr;
   logic [31:0] PC;
   logic [31:0] IFID_instr;
   logic [31:0] IFID_pc4;
   logic        IFID_valid;
   logic        Halt;

   logic [31:0] mem [0:31];

   logic [31:0] m_pc, m_instr, m_pc4;
   logic        m_valid;
   int          total = 0;
   int          fails = 0;

   if_fetch_stage #(
      .RESET_PC(32'd0),
      .IM_BYTES(84)
   ) dut (
      .clk(clk),
      .rst(rst),
      .Stall(Stall),
      .Flush(Flush),
      .Redirect(Redirect),
      .Redirect_addr(Redirect_addr),
      .IM_addr(IM_addr),
      .IM_instr(IM_instr),
      .PC(PC),
      .IFID_instr(IFID_instr),
      .IFID_pc4(IFID_pc4),
      .IFID_valid(IFID_valid),
      .Halt(Halt)
   );

   always #5 clk = ~clk;

   always_comb IM_instr = (IM_addr <= LAST) ? mem[IM_addr[6:2]] : 32'hFFFF_FFFF;

   function automatic logic inr(input logic [31:0] a);
      return a <= LAST;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One clock: apply inputs, advance the model by the priority rules, compare everything.
   task automatic step(input logic r, input logic st, input logic fl, input logic rd,
                       input logic [31:0] ra);
      logic [31:0] w, p4, npc;
      rst = r; Stall = st; Flush = fl; Redirect = rd; Redirect_addr = ra;
      w   = inr(m_pc) ? mem[m_pc[6:2]] : 32'hFFFF_FFFF;
      p4  = m_pc + 32'd4;
      npc = m_pc;
      if (r || rd) begin
         npc = r ? 32'd0 : {ra[31:2], 2'b00};
         m_instr = 0; m_pc4 = 0; m_valid = 0;
      end else if (st) begin
         if (fl) begin m_instr = 0; m_pc4 = 0; m_valid = 0; end
      end else if (!inr(m_pc)) begin
         m_instr = 0; m_pc4 = 0; m_valid = 0;
      end else begin
`ifdef IF_EARLY_JUMP_EN
         npc = (w[31:26] == 6'd2) ? {p4[31:28], w[25:0], 2'b00} : p4;
`else
         npc = p4;
`endif
         if (fl) begin m_instr = 0; m_pc4 = 0; m_valid = 0; end
         else begin m_instr = w; m_pc4 = p4; m_valid = 1; end
      end
      @(posedge clk);
      #1;
      m_pc = npc;
      chk("pc", PC, m_pc);
      chk("im_addr", IM_addr, m_pc);
      chk("ifid_instr", IFID_instr, m_instr);
      chk("ifid_pc4", IFID_pc4, m_pc4);
      chk("ifid_valid", IFID_valid, m_valid);
      chk("halt", Halt, !inr(m_pc) && !r);
   endtask

   initial begin
      logic [31:0] w;
      rst = 1; Stall = 0; Flush = 0; Redirect = 0; Redirect_addr = 0;
      m_pc = 0; m_instr = 0; m_pc4 = 0; m_valid = 0;
      for (int i = 0; i < 32; i++) begin
         w = $urandom;
         if (w[31:26] == 6'd2) w[31:26] = 6'd3;
         mem[i] = w;
      end
      mem[0] = 32'h5109_4015;

      step(1, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0);
      chk("rst_pc", PC, 32'd0);
      chk("rst_im_addr", IM_addr, 32'd0);
      chk("rst_instr", IFID_instr, 32'd0);
      chk("rst_pc4", IFID_pc4, 32'd0);
      chk("rst_valid", IFID_valid, 1'b0);
      chk("rst_halt", Halt, 1'b0);

      // Sequential fetch
      step(0, 0, 0, 0, 0);
      chk("seq_pc4", PC, 32'd4);
      chk("seq_instr", IFID_instr, 32'h5109_4015);
      chk("seq_ifid_pc4", IFID_pc4, 32'd4);
      chk("seq_valid", IFID_valid, 1'b1);
      step(0, 0, 0, 0, 0);
      chk("seq_pc8", PC, 32'd8);

      // Stall then flush
      step(0, 1, 0, 0, 0);
      step(0, 1, 0, 0, 0);
      chk("stall_pc", PC, 32'd8);
      chk("stall_instr", IFID_instr, mem[1]);
      chk("stall_pc4", IFID_pc4, 32'd8);
      step(0, 0, 1, 0, 0);
      chk("flush_valid", IFID_valid, 1'b0);
      chk("flush_instr", IFID_instr, 32'd0);
      chk("flush_pc", PC, 32'd12);

      // Redirect during stall, low bits forced
      step(0, 1, 0, 1, 32'd43);
      chk("rs_pc", PC, 32'd40);
      chk("rs_valid", IFID_valid, 1'b0);
      step(0, 0, 0, 0, 0);
      chk("rs_target_instr", IFID_instr, mem[10]);
      chk("rs_target_pc4", IFID_pc4, 32'd44);

      // Jump at 76
      mem[19] = {6'd2, 26'd16};
      step(0, 0, 0, 1, 32'd76);
      chk("j_at76", PC, 32'd76);
      step(0, 0, 0, 0, 0);
`ifdef IF_EARLY_JUMP_EN
      chk("ej_pc", PC, 32'd64);
      chk("ej_instr", IFID_instr, {6'd2, 26'd16});
      chk("ej_pc4", IFID_pc4, 32'd80);
      chk("ej_valid", IFID_valid, 1'b1);
`else
      chk("nj_pc", PC, 32'd80);
      step(0, 0, 0, 1, 32'd64);
      chk("nj_redirect", PC, 32'd64);
`endif

      // Halt out of range, then recover by redirect
      mem[5] = {6'd2, 26'd125};
`ifdef IF_EARLY_JUMP_EN
      step(0, 0, 0, 1, 32'd20);
      step(0, 0, 0, 0, 0);
`else
      step(0, 0, 0, 1, 32'd500);
`endif
      chk("halt_pc", PC, 32'd500);
      chk("halt_flag", Halt, 1'b1);
      step(0, 0, 0, 0, 0);
      chk("halt_valid", IFID_valid, 1'b0);
      for (int i = 0; i < 5; i++) begin
         step(0, 0, 0, 0, 0);
         chk("halt_hold_pc", PC, 32'd500);
         chk("halt_hold_flag", Halt, 1'b1);
      end
      step(0, 0, 0, 1, 32'd24);
      chk("unhalt_flag", Halt, 1'b0);
      chk("unhalt_pc", PC, 32'd24);
      chk("unhalt_bubble", IFID_valid, 1'b0);
      step(0, 0, 0, 0, 0);
      chk("unhalt_instr", IFID_instr, mem[6]);
      chk("unhalt_pc4", IFID_pc4, 32'd28);

      // Reset mid-run beats Redirect and Stall
      step(0, 0, 0, 0, 0);
      step(1, 1, 0, 1, 32'd44);
      chk("midrst_pc", PC, 32'd0);
      chk("midrst_valid", IFID_valid, 1'b0);

      // Random traffic, some jumps with targets past the populated memory
      for (int i = 0; i < 32; i++) begin
         w = $urandom;
         if (w[31:26] == 6'd2) w[31:26] = 6'd3;
         if ($urandom_range(0, 5) == 0) w = {6'd2, 26'($urandom_range(0, 24))};
         mem[i] = w;
      end
      for (int i = 0; i < 400; i++) begin
         step(($urandom_range(0, 49) == 0), ($urandom_range(0, 4) == 0),
              ($urandom_range(0, 6) == 0), ($urandom_range(0, 7) == 0),
              ($urandom_range(0, 3) == 0) ? 32'($urandom) : 32'($urandom_range(0, 100)));
      end

      $display("%0d/%0d checks passed", total - fails, total);
      $finish;
   end

endmodule
